// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer for a single-port
// data memory (synchronous write, combinational read, word-indexed address).
// Optional feature macro: DMEM_ARB_LOCK_EN adds m0_lock/m1_lock so one requester
// can hold the memory across several commands (atomic read-modify-write).
//
// Handshake: a requester raises mX_req with a stable command (we/addr/wdata) and
// holds it until the one-cycle mX_gnt pulse. The completion follows as a
// one-cycle mX_rvalid in the next cycle, with mX_rdata/mX_err valid alongside it.
// A req still high in the cycle after gnt is treated as a new request.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
`endif
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m1_lock,
`endif
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        r_state, w_next_state;

  // Latched command; r_last is the port served most recently (1 after reset so port 0 wins the first tie)
  logic          r_last, r_owner, r_we, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          r_m0_rvalid, r_m0_err, r_m1_rvalid, r_m1_err;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  logic          w_req0, w_req1, w_take, w_win;
  logic          w_sel_we, w_sel_err;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

`ifdef DMEM_ARB_LOCK_EN
  logic          r_locked, r_lock_port;
  logic          w_sel_lock, w_own_req, w_own_lock;

  // While locked, only the lock owner is eligible for arbitration
  assign w_req0     = m0_req & ~(r_locked &  r_lock_port);
  assign w_req1     = m1_req & ~(r_locked & ~r_lock_port);
  assign w_sel_lock = w_win       ? m1_lock : m0_lock;
  assign w_own_req  = r_lock_port ? m1_req  : m0_req;
  assign w_own_lock = r_lock_port ? m1_lock : m0_lock;

  // Lock follows each latched command; an owner that is idle with lock low frees it
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_lock_port <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_take) begin
        r_locked    <= w_sel_lock;
        r_lock_port <= w_win;
      end else if (r_locked && !w_own_req && !w_own_lock) begin
        r_locked    <= 1'b0;
      end
    end
  end
`else
  assign w_req0 = m0_req;
  assign w_req1 = m1_req;
`endif

  // Round-robin choice: a lone request wins, a tie goes to the port not served last
  always_comb begin
    w_take = w_req0 | w_req1;
    if (w_req0 && w_req1) w_win = ~r_last;
    else                  w_win = w_req1;
  end

  assign w_sel_we    = w_win ? m1_we    : m0_we;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_sel_err   = (w_sel_addr >> DEPTH_LOG2) != '0;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: any eligible request starts a one-cycle access
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_take) w_next_state = ACCESS;
      ACCESS:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; out-of-range commands never write memory
  always_comb begin
    busy   = (r_state != IDLE);
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    mem_we = 1'b0;
    mem_a  = r_addr;
    mem_wd = r_wdata;
    if (r_state == ACCESS) begin
      m0_gnt = ~r_owner;
      m1_gnt =  r_owner;
      mem_we = r_we & ~r_err;
    end
  end

  // Command latch on arbitration; round-robin pointer moves when the access runs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_take) begin
      r_owner <= w_win;
      r_we    <= w_sel_we;
      r_err   <= w_sel_err;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end else if (r_state == ACCESS) begin
      r_last  <= r_owner;
    end
  end

  // Registered completion routed to the owner; rdata only changes on reads
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      if (r_state == ACCESS) begin
        if (!r_owner) begin
          r_m0_rvalid <= 1'b1;
          r_m0_err    <= r_err;
          if (!r_we) r_m0_rdata <= r_err ? '0 : mem_rd;
        end else begin
          r_m1_rvalid <= 1'b1;
          r_m1_err    <= r_err;
          if (!r_we) r_m1_rdata <= r_err ? '0 : mem_rd;
        end
      end
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m0_err    = r_m0_err;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rvalid = r_m1_rvalid;
  assign m1_err    = r_m1_err;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: bench for dmem_arbiter with an attached 64K-word memory and a
// transaction-level model (memory map, last-served port, per-port response state).
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK, rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we, busy;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
`ifdef DMEM_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH_LOG2(16)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] bg(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Attached memory: background pattern, word 0x2000 preset to 10, synchronous write
  logic [31:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = bg(32'(i));
    mem[16'h2000] = 32'd10;
    forever begin
      @(posedge CLK);
      if (mem_we) mem[mem_a[15:0]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[15:0]];

  // Reference model state
  logic [31:0] ref_mem [logic [31:0]];
  int          exp_last;
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
`ifdef DMEM_ARB_LOCK_EN
  bit          cmd_lock [2];
  bit          exp_locked;
  int          exp_lock_port;
`endif

  // Requester commands
  bit          req_v [2];
  logic        cmd_we [2];
  logic [31:0] cmd_addr [2];
  logic [31:0] cmd_wdata [2];

  int checks = 0;
  int passed = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return bg(a);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Driver tasks
  task automatic drive();
    m0_req = req_v[0]; m0_we = cmd_we[0]; m0_addr = cmd_addr[0]; m0_wdata = cmd_wdata[0];
    m1_req = req_v[1]; m1_we = cmd_we[1]; m1_addr = cmd_addr[1]; m1_wdata = cmd_wdata[1];
`ifdef DMEM_ARB_LOCK_EN
    m0_lock = req_v[0] & cmd_lock[0];
    m1_lock = req_v[1] & cmd_lock[1];
`endif
  endtask

  task automatic new_cmd(input int p, input bit rd_only);
    req_v[p]  = 1'b1;
    cmd_we[p] = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       cmd_addr[p] = 32'h0001_0000 + $urandom_range(0, 32'h7FFF_FFFF);
      1:       cmd_addr[p] = 32'h0000_FFFF;
      2, 3, 4: cmd_addr[p] = $urandom_range(0, 15);
      default: cmd_addr[p] = $urandom_range(0, 32'h0000_FFFF);
    endcase
    cmd_wdata[p] = $urandom;
`ifdef DMEM_ARB_LOCK_EN
    cmd_lock[p] = ($urandom_range(0, 3) == 0);
`endif
  endtask

  // Which port the arbiter should serve next, from the round-robin/lock rules
  function automatic int pick_winner();
    bit c0 = req_v[0];
    bit c1 = req_v[1];
`ifdef DMEM_ARB_LOCK_EN
    if (exp_locked) begin
      if (exp_lock_port == 1) c0 = 1'b0;
      else                    c1 = 1'b0;
    end
`endif
    if (c0 && c1) return (exp_last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  // One arbitration opportunity: IDLE sample, then ACCESS and response checks
  task automatic arb_round();
    int          w;
    bit          oor;
    logic [31:0] a;
    drive();
    w = pick_winner();
    tick();
    if (w < 0) begin
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_m0_gnt", m0_gnt, 1'b0);
      chk1("idle_m1_gnt", m1_gnt, 1'b0);
`ifdef DMEM_ARB_LOCK_EN
      if (exp_locked && !req_v[exp_lock_port]) exp_locked = 1'b0;
`endif
      return;
    end
    a   = cmd_addr[w];
    oor = (a >> 16) != 0;
    chk1("m0_gnt", m0_gnt, w == 0);
    chk1("m1_gnt", m1_gnt, w == 1);
    chk1("busy_access", busy, 1'b1);
    chk32("mem_a", mem_a, a);
    chk1("mem_we", mem_we, cmd_we[w] & ~oor);
    if (cmd_we[w] && !oor) chk32("mem_wd", mem_wd, cmd_wdata[w]);
    if (cmd_we[w]) begin
      if (!oor) ref_mem[a] = cmd_wdata[w];
    end else begin
      exp_rdata[w] = oor ? 32'd0 : ref_rd(a);
    end
    exp_err[w] = oor;
    exp_last   = w;
`ifdef DMEM_ARB_LOCK_EN
    exp_locked    = cmd_lock[w];
    exp_lock_port = w;
`endif
    req_v[w] = 1'b0;
    drive();
    tick();
    chk1("m0_rvalid", m0_rvalid, w == 0);
    chk1("m1_rvalid", m1_rvalid, w == 1);
    chk32("m0_rdata", m0_rdata, exp_rdata[0]);
    chk32("m1_rdata", m1_rdata, exp_rdata[1]);
    chk1("m0_err", m0_err, exp_err[0]);
    chk1("m1_err", m1_err, exp_err[1]);
    chk1("mem_we_idle", mem_we, 1'b0);
    chk1("busy_idle", busy, 1'b0);
    chk32("mem_a_hold", mem_a, a);
    if (cmd_we[w] && !oor) chk32("mem_content", mem[a[15:0]], cmd_wdata[w]);
  endtask

  task automatic model_reset();
    exp_last     = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_err[0]   = 1'b0;
    exp_err[1]   = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    exp_locked    = 1'b0;
    exp_lock_port = 0;
    cmd_lock[0]   = 1'b0;
    cmd_lock[1]   = 1'b0;
`endif
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; cmd_we[p] = 1'b0; cmd_addr[p] = '0; cmd_wdata[p] = '0;
    end
    model_reset();
    ref_mem[32'h2000] = 32'd10;
    rst_n = 1'b0;
    drive();
    tick();
    tick();

    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_m1_gnt", m1_gnt, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_a", mem_a, 32'd0);
    chk32("rst_mem_wd", mem_wd, 32'd0);
    chk32("rst_m0_rdata", m0_rdata, 32'd0);
    chk1("rst_m0_err", m0_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // m0 read of the preset word
    cmd_we[0] = 1'b0; cmd_addr[0] = 32'h0000_2000; req_v[0] = 1'b1;
    arb_round();
    chk32("tp_read_preset", m0_rdata, 32'd10);

    // m1 write then read back
    cmd_we[1] = 1'b1; cmd_addr[1] = 32'h0000_0010; cmd_wdata[1] = 32'hDEAD_BEEF; req_v[1] = 1'b1;
    arb_round();
    cmd_we[1] = 1'b0; req_v[1] = 1'b1;
    arb_round();
    chk32("tp_readback", m1_rdata, 32'hDEAD_BEEF);

    // Both ports requesting reads continuously: grants must alternate
    new_cmd(0, 1'b1);
    new_cmd(1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      arb_round();
      if (k < 5) for (int p = 0; p < 2; p++) if (!req_v[p]) new_cmd(p, 1'b1);
    end
    arb_round();

    // Out-of-range write and read, plus the top in-range word
    cmd_we[0] = 1'b1; cmd_addr[0] = 32'h0001_0000; cmd_wdata[0] = 32'h5555_AAAA; req_v[0] = 1'b1;
    arb_round();
    chk1("oor_write_err", m0_err, 1'b1);
    cmd_we[0] = 1'b0; cmd_addr[0] = 32'hFFFF_FFF0; req_v[0] = 1'b1;
    arb_round();
    chk32("oor_read_zero", m0_rdata, 32'd0);
    cmd_we[0] = 1'b0; cmd_addr[0] = 32'h0000_FFFF; req_v[0] = 1'b1;
    arb_round();
    chk1("top_word_err", m0_err, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) if (!req_v[p] && $urandom_range(0, 2) != 0) new_cmd(p, 1'b0);
      arb_round();
    end
    for (int k = 0; k < 8 && (req_v[0] || req_v[1]); k++) arb_round();

    // Reset in the middle of an m0 write access
    cmd_we[0] = 1'b1; cmd_addr[0] = 32'h0000_0123; cmd_wdata[0] = ~ref_rd(32'h0000_0123);
    req_v[0] = 1'b1;
    drive();
    tick();
    chk1("abort_gnt", m0_gnt, 1'b1);
    chk1("abort_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_we_dropped", mem_we, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_gnt_dropped", m0_gnt, 1'b0);
    req_v[0] = 1'b0;
    drive();
    tick();
    chk1("abort_no_rvalid", m0_rvalid, 1'b0);
    chk32("abort_mem_kept", mem[16'h0123], ref_rd(32'h0000_0123));
    rst_n = 1'b1;
    model_reset();
    tick();
    chk1("abort_busy_after", busy, 1'b0);
    new_cmd(0, 1'b1);
    new_cmd(1, 1'b1);
`ifdef DMEM_ARB_LOCK_EN
    cmd_lock[0] = 1'b0;
    cmd_lock[1] = 1'b0;
`endif
    arb_round();
    chk1("post_reset_m0_won", exp_last == 0, 1'b1);
    arb_round();

`ifdef DMEM_ARB_LOCK_EN
    // Locked read then unlocked write on m0 while m1 keeps requesting
    cmd_we[0] = 1'b0; cmd_addr[0] = 32'h0000_0040; cmd_lock[0] = 1'b1; req_v[0] = 1'b1;
    arb_round();
    cmd_we[0] = 1'b1; cmd_wdata[0] = 32'hC0DE_0001; cmd_lock[0] = 1'b0; req_v[0] = 1'b1;
    cmd_we[1] = 1'b0; cmd_addr[1] = 32'h0000_0040; cmd_lock[1] = 1'b0; req_v[1] = 1'b1;
    arb_round();
    chk1("lock_m0_kept_bus", exp_last == 0, 1'b1);
    arb_round();
    chk32("lock_m1_sees_write", m1_rdata, 32'hC0DE_0001);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (synchronous write, combinational read, word-indexed address).
- Port 0 serves the core load/store unit; port 1 serves a debug/DMA master.
- Round-robin grant; each access is latched, executed in one ACCESS cycle, and completed with a registered response pulse.
- Out-of-range addresses are blocked from memory and flagged.

Parameters:
- AW, 32, address width of requester and memory ports (word index, passed unchanged).
- DW, 32, data width.
- DEPTH_LOG2, 16, log2 of implemented memory words; addresses >= 2**DEPTH_LOG2 are out of range.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 request; held with cmd stable until m0_gnt.
- m0_we  in  1  port 0 write enable (1=write, 0=read).
- m0_addr  in  AW  port 0 word address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  one-cycle pulse: command accepted.
- m0_rvalid  out  1  one-cycle completion pulse (reads and writes).
- m0_rdata  out  DW  read data, valid with m0_rvalid.
- m0_err  out  1  out-of-range flag, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory combinational read data.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last=1 (port 0 wins first tie), cmd regs=0, all gnt/rvalid/err=0, rdata=0, mem_we=0 immediately. Reset mid-ACCESS aborts; no memory write occurs.
- FSM IDLE:
  - Neither req: stay IDLE.
  - One req: that port wins.
  - Both req: winner = !last.
  - Latch winner's we/addr/wdata and owner; compute range error = (addr >> DEPTH_LOG2) != 0; go ACCESS.
- FSM ACCESS:
  - mem_a=latched addr; mem_wd=latched wdata; mem_we = latched we & !range_err (combinational from state).
  - gnt_owner pulses this cycle.
  - At the clock edge: last=owner; capture completion; go IDLE.
- Response (cycle after ACCESS, registered):
  - rvalid_owner=1 for one cycle; err_owner=range_err.
  - rdata_owner = mem_rd on in-range reads; 0 on out-of-range reads; unchanged on writes.
  - err holds until the next completion on that port.
- Timing:
  - Latency: req seen in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2.
  - Max throughput: one access per 2 cycles.
  - Requester must drop or update req the cycle after gnt; a still-high req is a new request.
- mem_a outputs the latched address in all states. mem_we is 1 only in ACCESS.
- A non-winning request stays pending, unacknowledged, until granted; no starvation under round-robin.
- Simultaneous rvalid to one port and new arbitration in IDLE is legal.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN.
- When defined:
  - Adds inputs m0_lock, m1_lock (1 bit each), sampled with the command at latch time.
  - If the owner's latched lock=1, the next IDLE arbitration considers only that owner (other port waits), enabling atomic read-modify-write sequences.
  - Lock is released by a command latched with lock=0, or by the owner being idle in IDLE while lock is low.
  - Round-robin pointer still updates.
- When undefined: lock ports are absent; pure round-robin.

Test Plan:
- Reset, then m0 read addr 0x2000 with mem[0x2000]=10 -> m0_gnt at cycle 1, m0_rvalid at cycle 2, m0_rdata=10, m0_err=0, mem_we never 1.
- m1 write addr 0x0010, data 0xDEADBEEF -> mem_we=1 only in ACCESS with mem_a=0x0010 and mem_wd=0xDEADBEEF; then m1 read 0x0010 -> rdata 0xDEADBEEF.
- Both req continuously, reads -> grants alternate m0, m1, m0, m1; each rvalid is routed only to its owner.
- m0 write addr 0x00010000 -> mem_we stays 0, m0_rvalid=1 with m0_err=1; m0_rdata unchanged.
- rst_n asserted during ACCESS of an m0 write -> mem_we drops immediately, memory unchanged, no m0_rvalid; after release, busy=0 and m0 wins the first tie.
- (DMEM_ARB_LOCK_EN) m0 locked read then write with m1_req held high -> m1 is granted only after m0's unlocked write completes.
